// File: rtl/psram_arbiter.sv
// Shares the byte-wide PSRAM controller between the game loader, the CPU and the PPU.
// Define PSRAM_ARB_STATS_EN to build the saturating ack and lost-issue counters.
module psram_arbiter #(
  parameter int unsigned ADDR_W    = 24,
  parameter bit          CPU_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_din,
  output logic              ld_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_din,
  output logic              cpu_ack,
  output logic [7:0]        cpu_dout,
  input  logic              ppu_req,
  input  logic [ADDR_W-1:0] ppu_addr,
  output logic              ppu_ack,
  output logic [7:0]        ppu_dout,
  output logic              mc_read_a,
  output logic              mc_read_b,
  output logic              mc_write,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [7:0]        mc_din,
  input  logic              mc_busy,
  input  logic [7:0]        mc_dout_a,
  input  logic [7:0]        mc_dout_b,
  output logic [1:0]        grant_id,
  output logic [15:0]       stat_ld,
  output logic [15:0]       stat_cpu,
  output logic [15:0]       stat_ppu,
  output logic [15:0]       stat_lost
);

  localparam logic [1:0] GntNone = 2'd0;
  localparam logic [1:0] GntLd   = 2'd1;
  localparam logic [1:0] GntCpu  = 2'd2;
  localparam logic [1:0] GntPpu  = 2'd3;

  typedef enum logic [2:0] {StIdle, StIssue, StWaitHi, StWaitLo, StAck} state_e;

  state_e state_q;
  logic   rr_cpu_q;      // 1: CPU wins the next CPU/PPU tie
  logic   wait_cnt_q;
  logic   cpu_rd_q;
  logic   lost_issue_q;
  logic   lost_event;

  // Controller never acknowledged the strobe within two WAIT_HI cycles.
  assign lost_event = (state_q == StWaitHi) && !mc_busy && wait_cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      rr_cpu_q     <= CPU_FIRST;
      wait_cnt_q   <= 1'b0;
      cpu_rd_q     <= 1'b0;
      lost_issue_q <= 1'b0;
      mc_read_a    <= 1'b0;
      mc_read_b    <= 1'b0;
      mc_write     <= 1'b0;
      mc_addr      <= '0;
      mc_din       <= '0;
      ld_ack       <= 1'b0;
      cpu_ack      <= 1'b0;
      ppu_ack      <= 1'b0;
      cpu_dout     <= '0;
      ppu_dout     <= '0;
      grant_id     <= GntNone;
    end else begin
      lost_issue_q <= lost_issue_q | lost_event;
      case (state_q)
        StIdle: begin
          if (!mc_busy) begin
            if (ld_req) begin
              grant_id <= GntLd;
              mc_write <= 1'b1;
              mc_addr  <= ld_addr;
              mc_din   <= ld_din;
              cpu_rd_q <= 1'b0;
              state_q  <= StIssue;
            end else if (cpu_req && (rr_cpu_q || !ppu_req)) begin
              grant_id  <= GntCpu;
              mc_write  <= cpu_we;
              mc_read_a <= !cpu_we;
              mc_addr   <= cpu_addr;
              mc_din    <= cpu_din;
              cpu_rd_q  <= !cpu_we;
              rr_cpu_q  <= 1'b0;
              state_q   <= StIssue;
            end else if (ppu_req) begin
              grant_id  <= GntPpu;
              mc_read_b <= 1'b1;
              mc_addr   <= ppu_addr;
              cpu_rd_q  <= 1'b0;
              rr_cpu_q  <= 1'b1;
              state_q   <= StIssue;
            end
          end
        end
        StIssue: begin
          mc_read_a  <= 1'b0;
          mc_read_b  <= 1'b0;
          mc_write   <= 1'b0;
          wait_cnt_q <= 1'b0;
          state_q    <= StWaitHi;
        end
        StWaitHi: begin
          if (mc_busy) begin
            state_q <= StWaitLo;
          end else if (wait_cnt_q) begin
            // grant_id is kept so the abandoned owner stays visible.
            state_q <= StIdle;
          end else begin
            wait_cnt_q <= 1'b1;
          end
        end
        StWaitLo: begin
          if (!mc_busy) begin
            state_q <= StAck;
            case (grant_id)
              GntLd:  ld_ack <= 1'b1;
              GntCpu: begin
                cpu_ack <= 1'b1;
                if (cpu_rd_q) cpu_dout <= mc_dout_a;
              end
              GntPpu: begin
                ppu_ack  <= 1'b1;
                ppu_dout <= mc_dout_b;
              end
              default: ;
            endcase
          end
        end
        StAck: begin
          ld_ack   <= 1'b0;
          cpu_ack  <= 1'b0;
          ppu_ack  <= 1'b0;
          grant_id <= GntNone;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef PSRAM_ARB_STATS_EN
  logic ack_event;
  assign ack_event = (state_q == StWaitLo) && !mc_busy;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ld   <= '0;
      stat_cpu  <= '0;
      stat_ppu  <= '0;
      stat_lost <= '0;
    end else begin
      if (ack_event && (grant_id == GntLd) && (stat_ld != 16'hFFFF)) begin
        stat_ld <= stat_ld + 16'd1;
      end
      if (ack_event && (grant_id == GntCpu) && (stat_cpu != 16'hFFFF)) begin
        stat_cpu <= stat_cpu + 16'd1;
      end
      if (ack_event && (grant_id == GntPpu) && (stat_ppu != 16'hFFFF)) begin
        stat_ppu <= stat_ppu + 16'd1;
      end
      if (lost_event && (stat_lost != 16'hFFFF)) begin
        stat_lost <= stat_lost + 16'd1;
      end
    end
  end
`else
  assign stat_ld   = '0;
  assign stat_cpu  = '0;
  assign stat_ppu  = '0;
  assign stat_lost = '0;
`endif

endmodule

// File: doc/psram_arbiter.md
Name: psram_arbiter

Overview:
- Shares the single byte-wide PSRAM MemoryController between three requesters: the game loader, the CPU and the PPU.
- Sequences each access through the controller's one-shot strobe and busy handshake.
- Returns read data to the winning requester and pulses a per-requester acknowledge.
- Sits between GameLoader, CPU and PPU on one side and MemoryController on the other. It replaces the ad-hoc OR-ing of loader_write into the CPU write strobe.

Parameters:
- ADDR_W, 24, width of every address bus (byte address into PSRAM).
- CPU_FIRST, 1, round-robin pointer value after reset: 1 means the CPU wins the first CPU/PPU tie.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous reset, active low.
- ld_req  input  1  loader write request; held until ld_ack.
- ld_addr  input  ADDR_W  loader byte address.
- ld_din  input  8  loader write data.
- ld_ack  output  1  one-cycle pulse when the loader write is complete.
- cpu_req  input  1  CPU request; held until cpu_ack.
- cpu_we  input  1  1 = write, 0 = read.
- cpu_addr  input  ADDR_W  CPU byte address.
- cpu_din  input  8  CPU write data.
- cpu_ack  output  1  completion pulse.
- cpu_dout  output  8  read data; valid with cpu_ack, held until the next CPU read completes.
- ppu_req  input  1  PPU read request; held until ppu_ack. The PPU never writes.
- ppu_addr  input  ADDR_W  PPU byte address.
- ppu_ack  output  1  completion pulse.
- ppu_dout  output  8  read data; valid with ppu_ack, held until the next PPU read completes.
- mc_read_a  output  1  controller read strobe, port A (CPU reads).
- mc_read_b  output  1  controller read strobe, port B (PPU reads).
- mc_write  output  1  controller write strobe.
- mc_addr  output  ADDR_W  controller address.
- mc_din  output  8  controller write data.
- mc_busy  input  1  controller busy.
- mc_dout_a  input  8  controller port-A read data.
- mc_dout_b  input  8  controller port-B read data.
- grant_id  output  2  current owner: 0 none, 1 loader, 2 CPU, 3 PPU.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - All strobes, acks, dout registers and grant_id are cleared.
  - The round-robin pointer is set to CPU_FIRST.
- Reset mid-access: the arbiter abandons the access with no ack. If the controller is still busy, the arbiter stays in IDLE until mc_busy=0 before issuing again.
- IDLE state:
  - Stays in IDLE while mc_busy=1 or no request is pending.
  - Otherwise picks a winner on the clock edge.
  - Priority: the loader wins unconditionally. CPU vs PPU is round-robin: the pointer flips to the other requester after each CPU or PPU grant. Loader grants do not move the pointer.
  - On the same edge, registers mc_addr, mc_din and exactly one strobe (mc_write for loader or CPU write, mc_read_a for CPU read, mc_read_b for PPU read), and sets grant_id.
  - Next state is ISSUE.
- ISSUE state: the strobe is high for exactly this one cycle. On the next edge all strobes are cleared and the state moves to WAIT_HI. A strobe longer than one cycle is illegal, because the controller would restart.
- WAIT_HI state:
  - On mc_busy=1, moves to WAIT_LO.
  - If mc_busy is still 0 after 2 cycles in WAIT_HI, sets the sticky internal flag lost_issue, returns to IDLE with no ack, and keeps grant_id. The requester is re-arbitrated normally.
- WAIT_LO state: on mc_busy=0, moves to ACK. On the same edge it asserts the owner's ack and captures mc_dout_a into cpu_dout (CPU read) or mc_dout_b into ppu_dout (PPU read).
- ACK state: ack is high for this one cycle. Next edge: ack is cleared, grant_id goes to 0, state goes to IDLE.
- Requesters deassert req in the cycle after they see ack. A req still high in IDLE after ACK is treated as a new access.
- Latency with the controller idle (3-cycle busy):
  - req sampled at edge E0, strobe high during E0–E1, ack high during E5–E6.
  - Peak throughput is one access per 7 cycles.
- A requester that changes addr, we or din while req is high and before ack gives undefined results. The arbiter samples these only in IDLE.
- Requests arriving simultaneously are resolved by priority in the same edge. A losing requester waits with no timeout.

Optional Feature:
- Macro PSRAM_ARB_STATS_EN.
- Defined: adds outputs stat_ld, stat_cpu, stat_ppu (16 bits each). Each is a saturating count of completed acks per requester, cleared by reset. Also adds a 16-bit stat_lost counter of lost_issue events.
- Undefined: these ports still exist but are tied to 0, and no counter logic is built.

Test Plan:
- Idle, single CPU read: cpu_req=1, addr=0x000123; model returns mc_dout_a=0xA5 → mc_read_a high exactly 1 cycle, mc_addr=0x000123, cpu_ack 5 edges after the request is sampled, cpu_dout=0xA5.
- Loader and CPU request on the same edge → loader write issued first (mc_write, mc_din=ld_din), then CPU served; pointer unchanged by the loader grant.
- CPU and PPU held continuously for 6 accesses → grants alternate CPU,PPU,CPU,PPU,CPU,PPU, with ppu_dout taken from mc_dout_b.
- reset pulled low while in WAIT_LO → outputs 0 immediately; after release the arbiter holds off issuing until mc_busy=0, then serves the pending request normally.
- Controller model that never raises busy → arbiter returns to IDLE after 2 WAIT_HI cycles with no ack; stat_lost=1 when PSRAM_ARB_STATS_EN is defined.
- With PSRAM_ARB_STATS_EN defined: 3 loader writes, 2 CPU writes, 1 PPU read → stat_ld=3, stat_cpu=2, stat_ppu=1.
